uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: 8N1 frames on an asynchronous serial input, LSB first, idle high.
- Recovers bytes using the same clocks-per-bit prescaler as the transmitter (0x68 = 104 at 12 MHz gives 115200 baud).
- Delivers each byte with a one-cycle write strobe that connects directly to a uart_fifo write port.
- Sits between a board RX pin and the receive FIFO; forms the loopback partner of uart_tx.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops (minimum 2).
- DATA_BITS, 8, data bits per frame (fixed 8 in this revision).

Ports:
- CLK  input  1  system clock.
- rst  input  1  reset.
- RX  input  1  asynchronous serial line, idle high.
- prescaler_in  input  21  clocks per bit; latched at start-bit detection.
- full  input  1  downstream FIFO full.
- data  output  8  last received byte; held until the next good frame.
- rx_valid  output  1  one-cycle strobe; data is valid in the same cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- overrun  output  1  sticky: a good byte completed while full=1.
- rx_active  output  1  high from start detection to the end of the stop-bit sample.

Interface (already decided): one clock; reset is asynchronous and active-high (CLK, rst).

Behaviour:
- Reset values: data=0, rx_valid=0, frame_err=0, overrun=0, rx_active=0, state=IDLE, synchronizer flops=1, counters=0.
- A reset asserted mid-frame aborts the frame with no strobe.
- Synchronizer: RX passes through SYNC_STAGES flops to give rx_s; latency is SYNC_STAGES cycles.
- Prescaler latch: P = max(prescaler_in, 4), captured on the IDLE->START transition. Changes to prescaler_in mid-frame are ignored.
- Counter cnt is 21 bits, cleared on every state transition.
- State IDLE: when rx_s==0, go to START and set rx_active=1.
- State START: at cnt==(P>>1)-1 (mid-bit), sample rx_s.
  - rx_s==0: go to DATA with bit_idx=0.
  - rx_s==1: treat as a glitch; go to IDLE, rx_active=0, no strobe.
- State DATA: at cnt==P-1, shift rx_s into the shift register MSB (right shift) and increment bit_idx. After bit_idx reaches 7, go to STOP (or PARITY when the optional feature is built in).
- State STOP: at cnt==P-1, sample rx_s and drop rx_active.
  - rx_s==1, full==0: data<=shift register, rx_valid=1 for one cycle, go to IDLE.
  - rx_s==1, full==1: data updates, rx_valid stays 0, overrun<=1, go to IDLE.
  - rx_s==0: frame_err=1 for one cycle, data unchanged, go to BREAK.
- State BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Sampling points: mid-bit for every bit. The start sample is at P/2; each later sample follows the previous one by exactly P cycles.
- Latency: rx_valid rises SYNC_STAGES + (P>>1) + 9*P cycles (±1) after the RX falling edge of the start bit.
- Back-to-back frames: a start bit may begin in the cycle after the stop-bit sample. No extra idle time is required.
- overrun is cleared only by rst.
- Strobes are mutually exclusive: rx_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP and an output port parity_err (1-bit, reset 0).
  - The parity bit is sampled at cnt==P-1 and compared against even parity of the 8 data bits.
  - On mismatch, a good stop bit produces a parity_err one-cycle strobe instead of rx_valid; data is not updated.
  - Frame length becomes 11 bits and rx_valid latency grows by P.
- Undefined: no PARITY state, no parity_err port, 10-bit 8N1 frames.

Test Plan:
- P=0x68, full=0, drive 0x48 (bits 0,0,0,1,0,0,1,0 then stop 1) -> exactly one rx_valid pulse 991..995 cycles after the start edge, data=0x48, frame_err=0, rx_active high throughout.
- P=0x68, send "Hello World!\r\n" back-to-back with no idle gap -> 14 rx_valid pulses with data 48 65 6C 6C 6F 20 57 6F 72 6C 64 21 0D 0A in order, no errors.
- P=0x68, RX low pulse of 20 cycles while idle -> no rx_valid, no frame_err; FSM back in IDLE by cycle 52+SYNC_STAGES; rx_active falls.
- P=0x68, send 0x55 with the stop bit low, then hold RX low for 3000 cycles, then release -> one frame_err pulse, no rx_valid, rx_active=0 while held low; a following 0xA5 frame is received correctly.
- P=0x68, full=1 during 0x3C frame -> rx_valid stays 0, overrun=1 and stays 1 after full drops; assert rst mid-frame -> all outputs 0, and the next 0x81 frame is received correctly.
- UART_RX_PARITY_EN defined, P=0x68: send 0x07 with parity bit 1 -> rx_valid, data=0x07; send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid, data stays 0x07.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err strobe.
module uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 8
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 RX,
  input  logic [20:0]          prescaler_in,
  input  logic                 full,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_active
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [20:0]            r_cnt, w_cnt_n;
  logic [20:0]            r_p, w_p_n;
  logic [DATA_BITS-1:0]   r_shift, w_shift_n;
  logic [IW-1:0]          r_idx, w_idx_n;
  logic [DATA_BITS-1:0]   r_data, w_data_n;
  logic                   r_valid, w_valid_n;
  logic                   r_ferr, w_ferr_n;
  logic                   r_ovr, w_ovr_n;
  logic                   r_pbad, w_pbad_n;
  logic                   r_perr, w_perr_n;

  logic        w_rx_s;
  logic [20:0] w_p_lat;
  logic        w_mid;
  logic        w_end;

  assign w_rx_s  = r_sync[SYNC_STAGES-1];
  assign w_p_lat = (prescaler_in < 21'd4) ? 21'd4 : prescaler_in;
  assign w_mid   = (r_cnt == ((r_p >> 1) - 21'd1));
  assign w_end   = (r_cnt == (r_p - 21'd1));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else if (SYNC_STAGES > 1) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RX};
    end else begin
      r_sync <= RX;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_pbad  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_p     <= w_p_n;
      r_shift <= w_shift_n;
      r_idx   <= w_idx_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
      r_ovr   <= w_ovr_n;
      r_pbad  <= w_pbad_n;
      r_perr  <= w_perr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 21'd1;
    w_p_n     = r_p;
    w_shift_n = r_shift;
    w_idx_n   = r_idx;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    w_ovr_n   = r_ovr;
    w_pbad_n  = r_pbad;
    w_perr_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n  = '0;
        w_pbad_n = 1'b0;
        if (!w_rx_s) begin
          w_state_n = S_START;
          w_p_n     = w_p_lat;
        end
      end
      S_START: begin
        if (w_mid) begin
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_state_n = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_end) begin
          w_cnt_n   = '0;
          w_shift_n = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_idx_n   = r_idx + 1'b1;
          if (r_idx == LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_end) begin
          w_cnt_n   = '0;
          w_pbad_n  = (w_rx_s != ^r_shift);
          w_state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_end) begin
          w_cnt_n = '0;
          if (!w_rx_s) begin
            w_ferr_n  = 1'b1;
            w_state_n = S_BREAK;
          end else begin
            w_state_n = S_IDLE;
            if (r_pbad) begin
              w_perr_n = 1'b1;
            end else begin
              w_data_n = r_shift;
              if (full) w_ovr_n = 1'b1;
              else      w_valid_n = 1'b1;
            end
          end
        end
      end
      S_BREAK: begin
        w_cnt_n = '0;
        if (w_rx_s) w_state_n = S_IDLE;
      end
      default: begin
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign rx_active = (r_state != S_IDLE) && (r_state != S_BREAK);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule
